// File: rtl/iir_filter_pkg.sv
// Shared widths, derivations and helpers for the iir_filter_5taps slice.
//
// Contents:
//   IIR_DATA_BIT_NUM / IIR_COEF_W / IIR_COEF_FRAC - default sample/coefficient formats
//   acc_width()   - accumulator width with guard bits for nine summed products
//   round_const() - half-LSB constant added before the fractional shift
//   narrow()      - reduce a scaled result to the sample width
//
// Build option: IIR_FILTER_SAT_EN selects saturation in narrow(); otherwise the
// result wraps (two's-complement truncation).
package iir_filter_pkg;

    localparam int unsigned IIR_DATA_BIT_NUM = 16;
    localparam int unsigned IIR_COEF_W       = 16;
    localparam int unsigned IIR_COEF_FRAC    = 14;
    // Nine products need ceil(log2(9)) = 4 extra bits to never overflow.
    localparam int unsigned IIR_GUARD_BITS   = 4;

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w);
        return data_w + coef_w + IIR_GUARD_BITS;
    endfunction

    localparam int unsigned IIR_ACC_W = acc_width(IIR_DATA_BIT_NUM, IIR_COEF_W);

    function automatic logic signed [63:0] round_const(input int unsigned frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

    // Works on a 64-bit carrier so one function serves any sample width < 64.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] r,
                                                  input int unsigned w);
`ifdef IIR_FILTER_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
`else
        // Keep the low w bits and sign-extend them back over the carrier.
        return (r <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/iir_mac_tap.sv
// One filter tap: signed sample times a fixed signed coefficient, sign-extended
// to the accumulator width so the top level can sum taps without overflow.
//
// Ports:
//   sample - signed DATA_BIT_NUM-bit tap input
//   prod   - signed ACC_W-bit product
module iir_mac_tap import iir_filter_pkg::*; #(
    parameter int unsigned DATA_BIT_NUM = IIR_DATA_BIT_NUM,
    parameter int unsigned COEF_W       = IIR_COEF_W,
    parameter int unsigned ACC_W        = IIR_ACC_W,
    parameter int          COEF         = 0
) (
    input  logic signed [DATA_BIT_NUM-1:0] sample,
    output logic signed [ACC_W-1:0]        prod
);

    localparam int unsigned PROD_W = DATA_BIT_NUM + COEF_W;
    localparam logic signed [COEF_W-1:0] COEF_Q = COEF_W'(COEF);

    logic signed [PROD_W-1:0] sample_x;
    logic signed [PROD_W-1:0] coef_x;
    logic signed [PROD_W-1:0] full;

    // Extend both operands to the full product width so the multiply is exact.
    assign sample_x = {{COEF_W{sample[DATA_BIT_NUM-1]}}, sample};
    assign coef_x   = {{DATA_BIT_NUM{COEF_Q[COEF_W-1]}}, COEF_Q};
    assign full     = sample_x * coef_x;
    assign prod     = {{(ACC_W - PROD_W){full[PROD_W-1]}}, full};

endmodule

// File: rtl/iir_filter_5taps.sv
// 4th-order Direct Form I IIR section: five feed-forward taps (B0..B4) on the
// input history and four feedback taps (A1..A4) on the stored output history.
// One sample in and one registered sample out per clock, no enable.
//
//   y[n] = narrow(round(B0*x[n] + B1*x1 + .. + B4*x4 - A1*y1 - .. - A4*y4))
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears all history and data_out
//   data_in  - signed input sample x[n]
//   data_out - signed filtered output y[n], one cycle after x[n] is sampled
//
// Build option: define IIR_FILTER_SAT_EN to saturate the result to the sample
// range; by default it wraps.
module iir_filter_5taps import iir_filter_pkg::*; #(
    parameter int unsigned DATA_BIT_NUM = IIR_DATA_BIT_NUM,
    parameter int unsigned COEF_W       = IIR_COEF_W,
    parameter int unsigned COEF_FRAC    = IIR_COEF_FRAC,
    parameter int unsigned ACC_W        = acc_width(DATA_BIT_NUM, COEF_W),
    parameter int          B0           = 8192,
    parameter int          B1           = 0,
    parameter int          B2           = 0,
    parameter int          B3           = 0,
    parameter int          B4           = 0,
    parameter int          A1           = -8192,
    parameter int          A2           = 0,
    parameter int          A3           = 0,
    parameter int          A4           = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_BIT_NUM-1:0] data_in,
    output logic signed [DATA_BIT_NUM-1:0] data_out
);

    localparam int B_COEF [0:4] = '{B0, B1, B2, B3, B4};
    localparam int A_COEF [1:4] = '{A1, A2, A3, A4};
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(COEF_FRAC));

    logic signed [DATA_BIT_NUM-1:0] x_q [1:4];
    logic signed [DATA_BIT_NUM-1:0] y_q [1:4];
    logic signed [DATA_BIT_NUM-1:0] x_tap [0:4];
    logic signed [ACC_W-1:0]        b_prod [0:4];
    logic signed [ACC_W-1:0]        a_prod [1:4];

    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        scaled;
    logic signed [63:0]             r64;
    logic signed [63:0]             narrow64;
    logic signed [DATA_BIT_NUM-1:0] y_d;
    logic                           unused_narrow_hi;

    assign x_tap[0] = data_in;
    for (genvar i = 1; i <= 4; i++) begin : g_xtap
        assign x_tap[i] = x_q[i];
    end

    for (genvar i = 0; i <= 4; i++) begin : g_b
        iir_mac_tap #(
            .DATA_BIT_NUM (DATA_BIT_NUM),
            .COEF_W       (COEF_W),
            .ACC_W        (ACC_W),
            .COEF         (B_COEF[i])
        ) u_tap (
            .sample (x_tap[i]),
            .prod   (b_prod[i])
        );
    end

    for (genvar i = 1; i <= 4; i++) begin : g_a
        iir_mac_tap #(
            .DATA_BIT_NUM (DATA_BIT_NUM),
            .COEF_W       (COEF_W),
            .ACC_W        (ACC_W),
            .COEF         (A_COEF[i])
        ) u_tap (
            .sample (y_q[i]),
            .prod   (a_prod[i])
        );
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i <= 4; i++) begin
            acc = acc + b_prod[i];
        end
        // Feedback taps are subtracted, so a negative A gives positive feedback.
        for (int i = 1; i <= 4; i++) begin
            acc = acc - a_prod[i];
        end
    end

    // Adding half an LSB then shifting arithmetically rounds ties toward +inf.
    assign scaled   = (acc + RND) >>> COEF_FRAC;
    assign r64      = {{(64 - ACC_W){scaled[ACC_W-1]}}, scaled};
    assign narrow64 = narrow(r64, DATA_BIT_NUM);
    assign y_d      = narrow64[DATA_BIT_NUM-1:0];

    // After narrowing, the upper carrier bits are only sign copies.
    assign unused_narrow_hi = ^narrow64[63:DATA_BIT_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= 4; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            x_q[4] <= x_q[3];
            x_q[3] <= x_q[2];
            x_q[2] <= x_q[1];
            x_q[1] <= data_in;
            y_q[4] <= y_q[3];
            y_q[3] <= y_q[2];
            y_q[2] <= y_q[1];
            y_q[1] <= y_d;
        end
    end

    // y1 is exactly the registered output, so it drives data_out directly.
    assign data_out = y_q[1];

endmodule

// File: tb/tb_iir_filter_5taps.sv
module tb_iir_filter_5taps;

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] exp;
    } vec_t;

    logic               clk;
    logic               rst;
    logic signed [15:0] din  [4];
    logic signed [15:0] dout [4];

    int vectors;
    int miscompares;

    // Coefficients per instance for the reference model (a index 1..4).
    longint mb [4][5];
    longint ma [4][5];
    // Model history: mx[k] = x[n-k], my[k] = y[n-k].
    longint mx [4][5];
    longint my [4][5];

    // 0: default, 1: passthrough, 2: overflow gain, 3: all taps active
    iir_filter_5taps u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din[0]),
        .data_out (dout[0])
    );

    iir_filter_5taps #(
        .B0 (16384),
        .A1 (0)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din[1]),
        .data_out (dout[1])
    );

    iir_filter_5taps #(
        .B0 (32767),
        .A1 (0)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din[2]),
        .data_out (dout[2])
    );

    iir_filter_5taps #(
        .B0 (6000),
        .B1 (-3000),
        .B2 (12000),
        .B3 (-9000),
        .B4 (2500),
        .A1 (-8000),
        .A2 (5000),
        .A3 (-3000),
        .A4 (1500)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (din[3]),
        .data_out (dout[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic longint narrow_ref(input longint r);
`ifdef IIR_FILTER_SAT_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
`else
        longint m;
        m = (r + 32768) % 65536;
        if (m < 0) m = m + 65536;
        return m - 32768;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
                mx[d][k] = 0;
                my[d][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int id, input longint x, output longint y);
        longint acc;
        mx[id][0] = x;
        acc = 0;
        for (int k = 0; k < 5; k++) acc = acc + mb[id][k] * mx[id][k];
        for (int k = 1; k < 5; k++) acc = acc - ma[id][k] * my[id][k];
        y = narrow_ref((acc + 8192) >>> 14);
        for (int k = 4; k >= 1; k--) mx[id][k] = mx[id][k-1];
        for (int k = 4; k >= 2; k--) my[id][k] = my[id][k-1];
        my[id][1] = y;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t step_tbl [11];
    vec_t pass_tbl [7];
    vec_t ovf_tbl  [5];

    initial begin
        longint e0;
        longint e3;
        longint x0;
        longint x3;
        longint exp_imp;

        vectors     = 0;
        miscompares = 0;

        // Step response of y = 0.5x + 0.5y1, ties rounded toward +inf.
        step_tbl[0]  = '{16'sd1000, 16'sd500};
        step_tbl[1]  = '{16'sd1000, 16'sd750};
        step_tbl[2]  = '{16'sd1000, 16'sd875};
        step_tbl[3]  = '{16'sd1000, 16'sd938};
        step_tbl[4]  = '{16'sd1000, 16'sd969};
        step_tbl[5]  = '{16'sd1000, 16'sd985};
        step_tbl[6]  = '{16'sd1000, 16'sd993};
        step_tbl[7]  = '{16'sd1000, 16'sd997};
        step_tbl[8]  = '{16'sd1000, 16'sd999};
        step_tbl[9]  = '{16'sd1000, 16'sd1000};
        step_tbl[10] = '{16'sd1000, 16'sd1000};

        pass_tbl[0] = '{16'sd100,    16'sd100};
        pass_tbl[1] = '{-16'sd200,   -16'sd200};
        pass_tbl[2] = '{16'sd32767,  16'sd32767};
        pass_tbl[3] = '{-16'sd32768, -16'sd32768};
        pass_tbl[4] = '{16'sd0,      16'sd0};
        pass_tbl[5] = '{16'sd1,      16'sd1};
        pass_tbl[6] = '{-16'sd1,     -16'sd1};

        // 32767*30000/16384 = 59998.2 -> 59998; wraps to -5538.
`ifdef IIR_FILTER_SAT_EN
        ovf_tbl[0] = '{16'sd30000,  16'sd32767};
        ovf_tbl[1] = '{-16'sd30000, -16'sd32768};
`else
        ovf_tbl[0] = '{16'sd30000,  -16'sd5538};
        ovf_tbl[1] = '{-16'sd30000, 16'sd5538};
`endif
        ovf_tbl[2] = '{16'sd1000,   16'sd2000};
        ovf_tbl[3] = '{-16'sd1,     -16'sd2};
        ovf_tbl[4] = '{16'sd16384,  16'sd32767};

        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
                mb[d][k] = 0;
                ma[d][k] = 0;
            end
        end
        mb[0][0] = 8192;  ma[0][1] = -8192;
        mb[3][0] = 6000;  mb[3][1] = -3000; mb[3][2] = 12000; mb[3][3] = -9000; mb[3][4] = 2500;
        ma[3][1] = -8000; ma[3][2] = 5000;  ma[3][3] = -3000; ma[3][4] = 1500;
        model_reset();

        // Reset held with nonzero input.
        rst = 1'b1;
        for (int d = 0; d < 4; d++) din[d] = 16'sd1234;
        repeat (5) begin
            tick();
            for (int d = 0; d < 4; d++) check("reset_hold", dout[d], 0);
        end

        // Step, then an asynchronous reset pulse at output 875.
        for (int d = 0; d < 4; d++) din[d] = 16'sd0;
        din[0] = step_tbl[0].din;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[0] = step_tbl[i].din;
            tick();
            check("step_pre", dout[0], step_tbl[i].exp);
        end
        #2 rst = 1'b1;
        #1 check("async_reset", dout[0], 0);
        tick();
        check("reset_pulse", dout[0], 0);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            din[0] = step_tbl[i].din;
            tick();
            check("step", dout[0], step_tbl[i].exp);
        end

        // Impulse: halves each cycle; rounding toward +inf keeps it at 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din[0] = 16'sd16384;
        tick();
        check("impulse_first", dout[0], 8192);
        din[0] = 16'sd0;
        exp_imp = 8192;
        for (int i = 0; i < 16; i++) begin
            exp_imp = (exp_imp + 1) >>> 1;
            tick();
            check("impulse", dout[0], exp_imp);
        end

        for (int i = 0; i < 7; i++) begin
            din[1] = pass_tbl[i].din;
            tick();
            check("passthrough", dout[1], pass_tbl[i].exp);
        end
        din[1] = 16'sd0;

        for (int i = 0; i < 5; i++) begin
            din[2] = ovf_tbl[i].din;
            tick();
            check("overflow", dout[2], ovf_tbl[i].exp);
        end
        din[2] = 16'sd0;

        // Random stimulus against the difference-equation model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 300; i++) begin
            din[0] = 16'($urandom);
            din[3] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) din[3] = ($urandom_range(0, 1) != 0) ? 16'sd32767 : -16'sd32768;
            if (i == 150) begin
                rst = 1'b1;
                tick();
                check("rand_reset0", dout[0], 0);
                check("rand_reset3", dout[3], 0);
                rst = 1'b0;
                model_reset();
            end else begin
                x0 = din[0];
                x3 = din[3];
                tick();
                model_step(0, x0, e0);
                model_step(3, x3, e3);
                check("rand_default", dout[0], e0);
                check("rand_alltaps", dout[3], e3);
            end
        end

        // Zero input from reset stays at zero.
        rst = 1'b1;
        din[0] = 16'sd0;
        din[3] = 16'sd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("zero_in", dout[3], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
